// File: rtl/mem_pkg.sv
// Shared types and helpers for the instruction/data memory subsystem.
package mem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // Index width for an array of n entries; never below 1 so slices stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_subsystem_if.sv
// Fetch, data and loader handshake signals of the memory subsystem.
interface mem_subsystem_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12
);
  logic                i_req;
  logic [ADDRSIZE-1:0] i_addr;
  logic                i_busy;
  logic                i_valid;
  logic [WIDTH-1:0]    i_rdata;
  logic                d_req;
  logic                d_we;
  logic [ADDRSIZE-1:0] d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic                d_busy;
  logic                d_valid;
  logic [WIDTH-1:0]    d_rdata;
  logic                ld_en;
  logic                ld_we;
  logic [ADDRSIZE-1:0] ld_addr;
  logic [WIDTH-1:0]    ld_wdata;
  logic                err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_en, ld_we, ld_addr, ld_wdata,
    output i_busy, i_valid, i_rdata, d_busy, d_valid, d_rdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_en, ld_we, ld_addr, ld_wdata,
    input  i_busy, i_valid, i_rdata, d_busy, d_valid, d_rdata, err
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// One memory port: accepts a request, counts out the latency and strobes
// the storage access on the last cycle before the valid pulse.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned LAT      = 1,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                stall_i,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] addr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic                drop_c_o,
  output logic                acc_en_c_o,
  output logic                acc_we_c_o,
  output logic [ADDRSIZE-1:0] acc_addr_c_o,
  output logic [WIDTH-1:0]    acc_wdata_c_o
);

  port_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic                we_q, we_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                accept_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // RESP behaves like IDLE for acceptance so back-to-back requests stream.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    accept_c   = req_i && !stall_i && (state_q != ST_WAIT);
    drop_c_o   = req_i && (state_q == ST_WAIT);
    acc_en_c_o = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          acc_en_c_o = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          if (LAT == 1) begin
            state_d    = ST_RESP;
            acc_en_c_o = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LAT - 2);
          end
        end
      end
    endcase
    busy_d  = (state_d == ST_WAIT);
    valid_d = (state_d == ST_RESP);
  end

  // Single-cycle ports access on the accepting edge, so use the live inputs.
  assign acc_we_c_o    = (state_q == ST_WAIT) ? we_q    : we_i;
  assign acc_addr_c_o  = (state_q == ST_WAIT) ? addr_q  : addr_i;
  assign acc_wdata_c_o = (state_q == ST_WAIT) ? wdata_q : wdata_i;
  assign busy_o        = busy_q;
  assign valid_o       = valid_q;

endmodule

// File: rtl/mem_subsystem.sv
// Instruction and data memories with latency-controlled ports, a program
// loader into instruction memory and a sticky error flag.
module mem_subsystem
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned I_DEPTH  = 4096,
  parameter int unsigned D_DEPTH  = 4096,
  parameter int unsigned I_LAT    = 1,
  parameter int unsigned D_LAT    = 2
) (
  input logic           clk,
  input logic           rst,
  mem_subsystem_if.slave bus
);

  localparam int unsigned I_IDX_W = clog2(I_DEPTH);
  localparam int unsigned D_IDX_W = clog2(D_DEPTH);

  logic [WIDTH-1:0]    i_mem [I_DEPTH];
  logic [WIDTH-1:0]    d_mem [D_DEPTH];
  logic                i_busy, i_valid, i_drop_c, i_acc_c, i_acc_we_c;
  logic [ADDRSIZE-1:0] i_acc_addr_c;
  logic [WIDTH-1:0]    i_acc_wdata_c;
  logic                d_busy, d_valid, d_drop_c, d_acc_c, d_acc_we_c;
  logic [ADDRSIZE-1:0] d_acc_addr_c;
  logic [WIDTH-1:0]    d_acc_wdata_c;
  logic                i_in_rng_c, d_in_rng_c, ld_in_rng_c, ld_wr_c, d_wr_c;
  logic [WIDTH-1:0]    i_rdata_q, d_rdata_q;
  logic                err_q, err_d;
  logic                unused_i_payload;

  mem_port_ctrl #(.LAT(I_LAT), .ADDRSIZE(ADDRSIZE), .WIDTH(WIDTH)) u_i_port (
    .clk(clk), .rst(rst),
    .req_i(bus.i_req), .stall_i(bus.ld_en), .we_i(1'b0), .addr_i(bus.i_addr), .wdata_i('0),
    .busy_o(i_busy), .valid_o(i_valid), .drop_c_o(i_drop_c), .acc_en_c_o(i_acc_c),
    .acc_we_c_o(i_acc_we_c), .acc_addr_c_o(i_acc_addr_c), .acc_wdata_c_o(i_acc_wdata_c)
  );

  mem_port_ctrl #(.LAT(D_LAT), .ADDRSIZE(ADDRSIZE), .WIDTH(WIDTH)) u_d_port (
    .clk(clk), .rst(rst),
    .req_i(bus.d_req), .stall_i(1'b0), .we_i(bus.d_we), .addr_i(bus.d_addr), .wdata_i(bus.d_wdata),
    .busy_o(d_busy), .valid_o(d_valid), .drop_c_o(d_drop_c), .acc_en_c_o(d_acc_c),
    .acc_we_c_o(d_acc_we_c), .acc_addr_c_o(d_acc_addr_c), .acc_wdata_c_o(d_acc_wdata_c)
  );

  assign unused_i_payload = ^{i_acc_we_c, i_acc_wdata_c};

  assign i_in_rng_c  = 32'(i_acc_addr_c) < I_DEPTH;
  assign d_in_rng_c  = 32'(d_acc_addr_c) < D_DEPTH;
  assign ld_in_rng_c = 32'(bus.ld_addr) < I_DEPTH;
  // Writes are gated by rst so an access aborted by reset never commits.
  assign ld_wr_c = rst && bus.ld_en && bus.ld_we && ld_in_rng_c;
  assign d_wr_c  = rst && d_acc_c && d_acc_we_c && d_in_rng_c;

  always_ff @(posedge clk) begin
    if (ld_wr_c) i_mem[bus.ld_addr[I_IDX_W-1:0]] <= bus.ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (d_wr_c) d_mem[d_acc_addr_c[D_IDX_W-1:0]] <= d_acc_wdata_c;
  end

  // Nonblocking reads here see the pre-edge contents (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (i_acc_c) i_rdata_q <= i_in_rng_c ? i_mem[i_acc_addr_c[I_IDX_W-1:0]] : '0;
      if (d_acc_c) d_rdata_q <= d_acc_we_c ? d_acc_wdata_c :
                                d_in_rng_c ? d_mem[d_acc_addr_c[D_IDX_W-1:0]] : '0;
      err_q <= err_d;
    end
  end

  assign err_d = err_q | i_drop_c | d_drop_c
               | (i_acc_c && !i_in_rng_c)
               | (d_acc_c && !d_in_rng_c)
               | (bus.ld_en && bus.ld_we && !ld_in_rng_c);

  assign bus.i_busy  = i_busy | bus.ld_en;
  assign bus.i_valid = i_valid;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_busy  = d_busy;
  assign bus.d_valid = d_valid;
  assign bus.d_rdata = d_rdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Scoreboard bench for mem_subsystem: directed scenarios then random traffic.
module tb_mem_subsystem;

  localparam int W     = 32;
  localparam int A     = 5;
  localparam int IDEP  = 16;
  localparam int DDEP  = 8;
  localparam int ILAT  = 1;
  localparam int DLAT  = 3;
  localparam int IIW   = $clog2(IDEP);
  localparam int DIW   = $clog2(DDEP);
  localparam int NEVER = 32'h7fffffff;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_subsystem_if #(.WIDTH(W), .ADDRSIZE(A)) bus ();

  mem_subsystem #(
    .WIDTH(W), .ADDRSIZE(A), .I_DEPTH(IDEP), .D_DEPTH(DDEP), .I_LAT(ILAT), .D_LAT(DLAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  exp_t         dq[$];
  exp_t         iq[$];
  logic [W-1:0] dmem_m[DDEP];
  logic [W-1:0] imem_m[IDEP];
  int           cyc = 0;
  int           d_lo = 1, d_hi = 0, i_lo = 1, i_hi = 0;
  int           err_from = NEVER;
  int           nchk = 0, nerr = 0;
  bit           pend_v = 0;
  int           pend_cyc, pend_addr;
  logic [W-1:0] pend_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void commit_due(input int c);
    if (pend_v && c > pend_cyc) begin
      dmem_m[DIW'(pend_addr)] = pend_data;
      pend_v = 0;
    end
  endfunction

  // One cycle of stimulus; expectations follow directly from the port rules.
  task automatic drive(input bit dreq, input bit dwe, input int daddr, input logic [W-1:0] dwd,
                       input bit ireq, input int iaddr,
                       input bit lden, input bit ldwe, input int ldaddr, input logic [W-1:0] ldwd);
    int   c;
    exp_t e;
    @(posedge clk);
    #1;
    c = cyc;
    commit_due(c);
    bus.d_req = dreq;  bus.d_we = dwe;  bus.d_addr = A'(daddr);  bus.d_wdata = dwd;
    bus.i_req = ireq;  bus.i_addr = A'(iaddr);
    bus.ld_en = lden;  bus.ld_we = ldwe;  bus.ld_addr = A'(ldaddr);  bus.ld_wdata = ldwd;
    if (dreq) begin
      if (c >= d_lo && c <= d_hi) err_from = imin(err_from, c + 1);
      else begin
        e.cyc = c + DLAT;
        if (dwe) begin
          e.data = dwd;
          if (daddr < DDEP) begin
            pend_v = 1; pend_cyc = c + DLAT - 1; pend_addr = daddr; pend_data = dwd;
          end
        end else begin
          e.data = (daddr < DDEP) ? dmem_m[DIW'(daddr)] : '0;
        end
        if (daddr >= DDEP) err_from = imin(err_from, c + DLAT);
        dq.push_back(e);
        d_lo = c + 1; d_hi = c + DLAT - 1;
      end
    end
    if (ireq) begin
      if (c >= i_lo && c <= i_hi) err_from = imin(err_from, c + 1);
      else if (!lden) begin
        e.cyc  = c + ILAT;
        e.data = (iaddr < IDEP) ? imem_m[IIW'(iaddr)] : '0;
        if (iaddr >= IDEP) err_from = imin(err_from, c + ILAT);
        iq.push_back(e);
        i_lo = c + 1; i_hi = c + ILAT - 1;
      end
    end
    if (lden && ldwe) begin
      if (ldaddr < IDEP) imem_m[IIW'(ldaddr)] = ldwd;
      else err_from = imin(err_from, c + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic dacc(input bit we, input int a, input logic [W-1:0] d);
    drive(1, we, a, d, 0, 0, 0, 0, 0, '0);
    idle(DLAT - 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    commit_due(cyc);
    pend_v = 0;
    rst = 1'b0;
    bus.d_req = 0; bus.i_req = 0; bus.ld_en = 0; bus.ld_we = 0;
    dq.delete(); iq.delete();
    d_lo = 1; d_hi = 0; i_lo = 1; i_hi = 0;
    err_from = NEVER;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a valid is due or presented.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ev;
    if (!rst) begin
      chk("reset_flags", W'({bus.d_valid, bus.i_valid, bus.d_busy, bus.i_busy, bus.err}), '0);
      chk("reset_rdata", bus.d_rdata | bus.i_rdata, '0);
    end else begin
      ev = (dq.size() > 0) && (dq[0].cyc == cyc);
      chk("d_valid", W'(bus.d_valid), W'(ev));
      if (ev) begin
        e = dq.pop_front();
        if (bus.d_valid) chk("d_rdata", bus.d_rdata, e.data);
      end
      ev = (iq.size() > 0) && (iq[0].cyc == cyc);
      chk("i_valid", W'(bus.i_valid), W'(ev));
      if (ev) begin
        e = iq.pop_front();
        if (bus.i_valid) chk("i_rdata", bus.i_rdata, e.data);
      end
      chk("d_busy", W'(bus.d_busy), W'(cyc >= d_lo && cyc <= d_hi));
      chk("i_busy", W'(bus.i_busy), W'((cyc >= i_lo && cyc <= i_hi) || bus.ld_en));
      chk("err", W'(bus.err), W'(cyc >= err_from));
    end
  end

  initial begin
    bit lden_r;
    int nc;
    bit dfree;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.ld_en = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    do_reset(2);

    // Preload both memories with known contents.
    for (int a = 0; a < IDEP; a++) drive(0, 0, 0, '0, 0, 0, 1, 1, a, $urandom);
    for (int a = 0; a < DDEP; a++) dacc(1, a, $urandom);
    idle(2);

    // Reset during a write's wait phase aborts it; addr 7 keeps its old word.
    drive(1, 1, 7, 99, 0, 0, 0, 0, 0, '0);
    do_reset(2);
    dacc(0, 7, '0);
    idle(2);

    // Write then back-to-back read of the same address.
    dacc(1, 5, 32'hDEAD);
    dacc(0, 5, '0);
    idle(2);

    // Single-cycle fetch streaming.
    for (int a = 0; a < 4; a++) drive(0, 0, 0, '0, 1, a, 0, 0, 0, '0);
    idle(2);

    // Loader stalls fetches, then the loaded word is fetched.
    for (int a = 0; a < 4; a++) drive(0, 0, 0, '0, 1, a, 1, 1, a, W'(10 + a));
    drive(0, 0, 0, '0, 1, 1, 1, 0, 0, '0);
    drive(0, 0, 0, '0, 1, 2, 0, 0, 0, '0);
    idle(2);

    // Dropped request while busy.
    drive(1, 0, 3, '0, 0, 0, 0, 0, 0, '0);
    idle(1);
    drive(1, 1, 4, 32'h1234, 0, 0, 0, 0, 0, '0);
    idle(DLAT);

    // Out-of-range read and write; addr 9 must not alias onto addr 1.
    dacc(0, 9, '0);
    dacc(1, 9, 5);
    dacc(0, 1, '0);
    idle(2);

    // Random traffic that stays legal: err must stay clear.
    do_reset(1);
    lden_r = 0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) lden_r = !lden_r;
      nc    = cyc + 1;
      dfree = !(nc >= d_lo && nc <= d_hi);
      drive(dfree && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)),
            $urandom_range(0, DDEP - 1), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, IDEP - 1),
            lden_r, 1'($urandom_range(0, 1)), $urandom_range(0, IDEP - 1), $urandom);
    end
    idle(DLAT + 1);

    // Unrestricted random traffic including drops and out-of-range addresses.
    do_reset(1);
    lden_r = 0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) lden_r = !lden_r;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, DDEP + 1), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, IDEP + 1),
            lden_r, 1'($urandom_range(0, 1)), $urandom_range(0, IDEP + 1), $urandom);
    end
    idle(DLAT + 2);

    chk("drain", W'(dq.size() + iq.size()), '0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_subsystem.md
Name: mem_subsystem

Overview:
- Synthesizable, parametrised instruction/data memory subsystem for the instruction_set_model CPU. Replaces the zero-latency behavioural I_MEM/MEM arrays.
- Provides an instruction read port, a data read/write port and a program-loader port.
- Access latency is configurable per port, with req/busy/valid handshakes. Out-of-range and dropped-request errors are reported on a sticky flag.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDRSIZE, 12, address width in bits.
- I_DEPTH, 4096, instruction words implemented (≤ 2^ADDRSIZE).
- D_DEPTH, 4096, data words implemented (≤ 2^ADDRSIZE).
- I_LAT, 1, instruction read latency in cycles (≥1, ≤15).
- D_LAT, 2, data access latency in cycles (≥1, ≤15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request
- i_addr  in  ADDRSIZE  fetch address
- i_busy  out  1  fetch in flight or loader active; i_req ignored
- i_valid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  WIDTH  fetched word
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read (sampled with d_req)
- d_addr  in  ADDRSIZE  data address
- d_wdata  in  WIDTH  write data
- d_busy  out  1  data access in flight
- d_valid  out  1  one-cycle completion pulse (read and write)
- d_rdata  out  WIDTH  read data; for writes, the written word
- ld_en  in  1  loader mode; blocks new fetches
- ld_we  in  1  loader write strobe (instruction memory)
- ld_addr  in  ADDRSIZE  loader address
- ld_wdata  in  WIDTH  loader data
- err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async): all port FSMs go to IDLE. i_busy, i_valid, d_busy, d_valid and err are 0; i_rdata and d_rdata are 0. Memory contents are not cleared. Reset mid-access aborts the access: no write is committed unless its commit edge has already passed.
- Per-port FSM states and transitions:
  - IDLE→WAIT on an accepted req when LAT>1; IDLE→RESP directly when LAT=1.
  - WAIT holds a down-counter loaded with LAT-2 and moves to RESP when it reaches 0.
  - RESP lasts one cycle: valid=1, busy=0. A new req in RESP is accepted (back-to-back).
- Timing: a req sampled high in cycle k gives valid in cycle k+LAT. busy is high in cycles k+1..k+LAT-1.
- Address, we and wdata are captured at accept; inputs need not be held after that.
- The memory access (read or write) happens at the edge ending cycle k+LAT-1. Read data reflects all writes committed at earlier edges.
- A data write followed by a back-to-back read of the same address returns the new value.
- A req while busy=1 is dropped and sets err. i_req while ld_en=1 and the port is idle is stalled, not an error: i_busy=1, no accept.
- Out of range: address ≥ I_DEPTH or ≥ D_DEPTH. Reads return 0, writes are discarded, valid still pulses, and err is set.
- Loader: ld_we=1 writes I_MEM[ld_addr] at the next edge (1 cycle). It is only honoured while ld_en=1. An out-of-range ld_addr is discarded and sets err.
- An in-flight fetch when ld_en rises completes normally. If a loader write and a fetch access hit the same address on the same edge, the fetch returns the old word (read-first).
- err clears only on reset.

Decomposition:
- Package mem_pkg holds the FSM state encoding (IDLE, WAIT, RESP), the 4-bit latency counter width constant, and the clog2 helper.
- One sub-module, mem_port_ctrl: FSM, counter, request capture, busy/valid/drop-error generation. It is parametrised by LAT and ADDRSIZE and instantiated twice, for the instruction and data ports.
- Storage arrays and the loader path live in mem_subsystem.

Test Plan:
1. Reset mid-access: D_LAT=2, d_req write addr 7 data 99, rst low in cycle k+1 → d_valid never pulses; after reset a read of addr 7 returns its pre-write value; err=0.
2. Latency/back-to-back: D_LAT=3, write addr 5 data 0xDEAD at cycle 0 → d_valid at cycle 3, d_busy in cycles 1–2. Read addr 5 issued in cycle 3 → d_valid at cycle 6, d_rdata=0xDEAD.
3. I_LAT=1 streaming: i_req held high with addr 0,1,2,3 on consecutive cycles → i_valid high in cycles 1–4, i_rdata matches preloaded words, i_busy stays 0.
4. Dropped request: D_LAT=4, second d_req at cycle 2 → ignored, err=1 from cycle 3, first access still completes at cycle 4.
5. Out of range: D_DEPTH=8, read addr 9 → d_valid pulses, d_rdata=0, err=1. Write addr 9 data 5 → memory unchanged.
6. Loader: ld_en=1, ld_we writes addr 0..3 with 10..13 while i_req is held → i_busy=1 throughout, no i_valid. Drop ld_en, fetch addr 2 → i_rdata=12.
